// File: rtl/wbn_arb_if.sv
// -----------------------------------------------------------------------------
// wbn_arb_if
// Bundle of every bus signal around the wbn_arb round-robin arbiter: the MN
// packed Wishbone master ports, the single shared slave port and the grant
// status. Master i occupies bit i or slice [i*W +: W] of the m_* vectors.
//
// Modports:
//   master : the surrounding system. It drives the master requests and the
//            shared-port responses, and observes the terminations, the
//            shared-port request and the grant status.
//   slave  : the arbiter itself. It is the slave of the MN masters and
//            drives the shared port.
// -----------------------------------------------------------------------------
interface wbn_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int MN = 2
);
  localparam int GW = $clog2(MN);

  // per-master request side
  logic [MN-1:0]    m_cyc;
  logic [MN-1:0]    m_we;
  logic [MN-1:0]    m_stb;
  logic [MN*AW-1:0] m_adr;
  logic [MN*SW-1:0] m_sel;
  logic [MN*DW-1:0] m_dat_w;
  // per-master response side (read data is broadcast)
  logic [DW-1:0]    m_dat_r;
  logic [MN-1:0]    m_ack;
  logic [MN-1:0]    m_err;
  logic [MN-1:0]    m_rty;
  // shared slave port
  logic             s_cyc;
  logic             s_we;
  logic             s_stb;
  logic [AW-1:0]    s_adr;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dat_w;
  logic [DW-1:0]    s_dat_r;
  logic             s_ack;
  logic             s_err;
  logic             s_rty;
  // grant status
  logic [GW-1:0]    gnt;
  logic             gnt_vld;

  modport master (
    output m_cyc, m_we, m_stb, m_adr, m_sel, m_dat_w,
    input  m_dat_r, m_ack, m_err, m_rty,
    input  s_cyc, s_we, s_stb, s_adr, s_sel, s_dat_w,
    output s_dat_r, s_ack, s_err, s_rty,
    input  gnt, gnt_vld
  );

  modport slave (
    input  m_cyc, m_we, m_stb, m_adr, m_sel, m_dat_w,
    output m_dat_r, m_ack, m_err, m_rty,
    output s_cyc, s_we, s_stb, s_adr, s_sel, s_dat_w,
    input  s_dat_r, s_ack, s_err, s_rty,
    output gnt, gnt_vld
  );
endinterface

// File: rtl/wbn_arb.sv
// -----------------------------------------------------------------------------
// wbn_arb
// Round-robin arbiter sharing one Wishbone 3 slave (normally wbn2apb) between
// MN masters. A grant is held for the owner's whole bus cycle (cyc high); the
// owner's request is muxed onto the shared port and the termination is routed
// back to the owner only. Read data is broadcast to every master.
//
// Parameters: AW address width, DW data width, SW byte-select width,
//             MN number of masters (2..8), TO watchdog limit in cycles.
// Ports:      clk  clock
//             rst  synchronous active-high reset
//             bus  wbn_arb_if.slave (master ports, shared port, gnt/gnt_vld)
//
// Optional feature macro: WBN_ARB_TIMEOUT_EN
//   When defined, a watchdog ends a stalled strobe after TO cycles with a
//   one-cycle error to the owner (state TOUT). When undefined, a stalled slave
//   holds the grant indefinitely.
// -----------------------------------------------------------------------------
module wbn_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int MN = 2,
  parameter int TO = 16
) (
  input logic      clk,
  input logic      rst,
  wbn_arb_if.slave bus
);
  localparam int GW = $clog2(MN);

  if (MN < 2 || MN > 8 || TO < 1) begin : g_param_chk
    $error("wbn_arb: MN must be 2..8 and TO at least 1");
  end

`ifdef WBN_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO + 1);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TOUT = 2'd2
  } state_t;
  logic [CW-1:0] cnt_r;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
  } state_t;
`endif

  state_t        state_r;
  logic [GW-1:0] gnt_r;
  logic [GW-1:0] last_r;
  logic          gnt_vld_r;

  logic [GW-1:0] nxt_gnt_s;
  logic          nxt_found_s;
  logic [GW-1:0] cand_s;
  logic          hit_s;
  logic          cur_cyc_s;
  logic          cur_stb_s;
  logic          term_s;

  assign cur_cyc_s   = bus.m_cyc[gnt_r];
  assign cur_stb_s   = bus.m_stb[gnt_r];
  assign term_s      = bus.s_ack | bus.s_err | bus.s_rty;
  assign bus.gnt     = gnt_r;
  assign bus.gnt_vld = gnt_vld_r;

  // Round-robin search: first requester upward from last_r+1, wrapping.
  always_comb begin
    nxt_found_s = 1'b0;
    nxt_gnt_s   = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 1; k <= MN; k++) begin
      cand_s      = GW'((int'(last_r) + k) % MN);
      hit_s       = bus.m_cyc[cand_s] & ~nxt_found_s;
      nxt_gnt_s   = hit_s ? cand_s : nxt_gnt_s;
      nxt_found_s = nxt_found_s | hit_s;
    end
  end

  // Shared-port request mux and termination routing to the owner only.
  always_comb begin
    bus.s_cyc   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_adr   = '0;
    bus.s_sel   = '0;
    bus.s_dat_w = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.m_rty   = '0;
    bus.m_dat_r = bus.s_dat_r;
    case (state_r)
      ST_BUSY: begin
        bus.s_cyc          = cur_cyc_s;
        bus.s_we           = bus.m_we[gnt_r];
        bus.s_stb          = cur_stb_s;
        bus.s_adr          = bus.m_adr[int'(gnt_r)*AW +: AW];
        bus.s_sel          = bus.m_sel[int'(gnt_r)*SW +: SW];
        bus.s_dat_w        = bus.m_dat_w[int'(gnt_r)*DW +: DW];
        bus.m_ack[gnt_r]   = bus.s_ack;
        bus.m_err[gnt_r]   = bus.s_err;
        bus.m_rty[gnt_r]   = bus.s_rty;
      end
`ifdef WBN_ARB_TIMEOUT_EN
      // Watchdog fired: shared port released, slave response ignored.
      ST_TOUT: begin
        bus.m_err[gnt_r] = 1'b1;
      end
`endif
      default: begin
        bus.s_cyc = 1'b0;
      end
    endcase
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      gnt_r     <= '0;
      gnt_vld_r <= 1'b0;
      last_r    <= GW'(MN - 1);   // master 0 wins the first tie
`ifdef WBN_ARB_TIMEOUT_EN
      cnt_r     <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
`ifdef WBN_ARB_TIMEOUT_EN
          cnt_r <= '0;
`endif
          if (nxt_found_s) begin
            state_r   <= ST_BUSY;
            gnt_r     <= nxt_gnt_s;
            last_r    <= nxt_gnt_s;
            gnt_vld_r <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            gnt_vld_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          // Release always wins; the shared port then sees one idle cycle.
          if (!cur_cyc_s) begin
            state_r   <= ST_IDLE;
            gnt_vld_r <= 1'b0;
`ifdef WBN_ARB_TIMEOUT_EN
            cnt_r     <= '0;
          end else if (!cur_stb_s || term_s) begin
            cnt_r <= '0;
          end else if (cnt_r == CW'(TO - 1)) begin
            // The count reaches TO on this edge: the next cycle is TOUT.
            state_r <= ST_TOUT;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
`endif
          end else begin
            state_r <= ST_BUSY;
          end
        end
`ifdef WBN_ARB_TIMEOUT_EN
        ST_TOUT: begin
          cnt_r <= '0;
          if (cur_cyc_s) begin
            state_r <= ST_BUSY;
          end else begin
            state_r   <= ST_IDLE;
            gnt_vld_r <= 1'b0;
          end
        end
`endif
        default: begin
          state_r   <= ST_IDLE;
          gnt_vld_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
